// File: rtl/puf_eval_ctrl.sv
// PUF evaluation controller: runs NUM_EVAL clear/measure/settle/sample rounds per
// challenge and majority-votes the 8 response bits. Optional macro PUF_EVAL_UNSTABLE_MASK_EN.
module puf_eval_ctrl #(
  parameter int WINDOW_CYCLES = 1024,
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_EVAL      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_challenge,
  output logic [7:0] puf_challenge,
  output logic       puf_enable,
  output logic       puf_clr,
  input  logic [7:0] puf_response,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_data,
  output logic [7:0] resp_unstable,
  output logic       busy
);

  localparam int              DATA_W    = 8;
  localparam logic [15:0]     WIN_LAST  = 16'(WINDOW_CYCLES - 1);
  localparam logic [15:0]     SET_LAST  = 16'(SETTLE_CYCLES - 1);
  localparam logic [3:0]      EVAL_LAST = 4'(NUM_EVAL - 1);
  localparam logic [3:0]      VOTE_HALF = 4'(NUM_EVAL / 2);
  localparam logic [3:0]      VOTE_ALL  = 4'(NUM_EVAL);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    MEASURE = 3'd2,
    SETTLE  = 3'd3,
    SAMPLE  = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [15:0]              timer;
  logic [3:0]               eval_cnt;
  logic [DATA_W-1:0][3:0]   ones;
  logic [DATA_W-1:0]        challenge_q;
  logic                     ready_en;
  logic                     accept;

  function automatic logic [DATA_W-1:0] majority(input logic [DATA_W-1:0][3:0] cnt);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < DATA_W; i++) v[i] = (cnt[i] > VOTE_HALF);
    return v;
  endfunction

`ifdef PUF_EVAL_UNSTABLE_MASK_EN
  function automatic logic [DATA_W-1:0] unstable_mask(input logic [DATA_W-1:0][3:0] cnt);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < DATA_W; i++) v[i] = (cnt[i] != 4'd0) && (cnt[i] != VOTE_ALL);
    return v;
  endfunction
`endif

  assign accept        = (state == IDLE) && req_valid && ready_en;
  assign puf_challenge = challenge_q;

  // State register and datapath counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      timer       <= '0;
      eval_cnt    <= '0;
      ones        <= '0;
      challenge_q <= '0;
      ready_en    <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
      // timer restarts on every state change so each timed state counts from zero
      if ((state_nxt != state) || !((state == MEASURE) || (state == SETTLE)))
        timer <= '0;
      else
        timer <= timer + 16'd1;
      if (accept) begin
        challenge_q <= req_challenge;
        eval_cnt    <= '0;
        ones        <= '0;
      end else if (state == SAMPLE) begin
        for (int i = 0; i < DATA_W; i++) ones[i] <= ones[i] + {3'b000, puf_response[i]};
        if (eval_cnt != EVAL_LAST) eval_cnt <= eval_cnt + 4'd1;
      end
    end
  end

  // Next-state and Moore outputs
  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    puf_clr       = 1'b0;
    puf_enable    = 1'b0;
    resp_valid    = 1'b0;
    resp_data     = '0;
    resp_unstable = '0;
    busy          = 1'b1;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        req_ready = ready_en;
        if (accept) state_nxt = CLEAR;
      end
      CLEAR: begin
        puf_clr   = 1'b1;
        state_nxt = MEASURE;
      end
      MEASURE: begin
        puf_enable = 1'b1;
        if (timer == WIN_LAST) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (timer == SET_LAST) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        state_nxt = (eval_cnt == EVAL_LAST) ? DONE : CLEAR;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_data  = majority(ones);
`ifdef PUF_EVAL_UNSTABLE_MASK_EN
        resp_unstable = unstable_mask(ones);
`endif
        if (resp_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Self-checking bench for puf_eval_ctrl with a behavioural PUF that returns one
// stored value per clear pulse and a vote model computed from per-bit counts.
module tb_puf_eval_ctrl;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int NE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_challenge = 8'h00;
  logic [7:0] puf_challenge;
  logic       puf_enable;
  logic       puf_clr;
  logic [7:0] puf_response = 8'h00;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [7:0] resp_data;
  logic [7:0] resp_unstable;
  logic       busy;

  int         n_total = 0;
  int         n_bad = 0;
  int         clr_total = 0;
  int         clr_base = 0;
  int         en_run = 0;
  logic [7:0] cur_chal = 8'h00;
  logic [7:0] model_vals [16];

  always #5 clk = ~clk;

  puf_eval_ctrl #(
    .WINDOW_CYCLES(W),
    .SETTLE_CYCLES(S),
    .NUM_EVAL(NE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_challenge(req_challenge),
    .puf_challenge(puf_challenge),
    .puf_enable(puf_enable),
    .puf_clr(puf_clr),
    .puf_response(puf_response),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .resp_unstable(resp_unstable),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Vote model: count ones per bit over the evaluations, strict majority wins.
  function automatic logic [15:0] ref_resp();
    logic [7:0] d;
    logic [7:0] u;
    int c;
    d = 8'h00;
    u = 8'h00;
    for (int b = 0; b < 8; b++) begin
      c = 0;
      for (int e = 0; e < NE; e++) c += int'(model_vals[e][b]);
      d[b] = (2 * c > NE);
`ifdef PUF_EVAL_UNSTABLE_MASK_EN
      u[b] = (c != 0) && (c != NE);
`endif
    end
    return {u, d};
  endfunction

  // Advance to the next falling edge, then run the per-cycle PUF model and invariant checks.
  task automatic tick();
    logic [3:0] idx;
    @(negedge clk);
    if (!rst) begin
      en_run = 0;
    end else begin
      chk("clr_en_overlap", 32'(puf_clr & puf_enable), 32'd0);
      if (puf_enable) en_run++;
      else if (en_run != 0) begin
        chk("enable_len", 32'(en_run), 32'(W));
        en_run = 0;
      end
      if (puf_clr) begin
        idx = 4'(clr_total - clr_base);
        puf_response = model_vals[idx];
        clr_total++;
      end
      if (busy) chk("chal_hold", 32'(puf_challenge), 32'(cur_chal));
    end
  endtask

  task automatic run_req(input logic [7:0] chal, input int hold);
    int k;
    logic [15:0] exp;
    k = 0;
    while (!req_ready && k < 100) begin
      tick();
      k++;
    end
    chk("ready_before_req", 32'(req_ready), 32'd1);
    clr_base      = clr_total;
    cur_chal      = chal;
    exp           = ref_resp();
    resp_ready    = (hold == 0);
    req_valid     = 1'b1;
    req_challenge = chal;
    tick();
    req_valid     = 1'b0;
    req_challenge = 8'($urandom);
    chk("clear_first", 32'(puf_clr), 32'd1);
    k = 0;
    while (!resp_valid && k < 200) begin
      tick();
      k++;
    end
    chk("latency", 32'(k), 32'(NE * (W + S + 2)));
    chk("resp_data", 32'(resp_data), 32'(exp[7:0]));
    chk("resp_unstable", 32'(resp_unstable), 32'(exp[15:8]));
    chk("puf_challenge", 32'(puf_challenge), 32'(chal));
    if (hold > 0) begin
      req_valid     = 1'b1;
      req_challenge = 8'h11;
      for (int i = 0; i < hold; i++) begin
        tick();
        chk("hold_valid", 32'(resp_valid), 32'd1);
        chk("hold_data", 32'(resp_data), 32'(exp[7:0]));
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
    end
    tick();
    if (hold > 0) resp_ready = 1'b0;
    chk("idle_after", 32'(busy), 32'd0);
    chk("ready_after", 32'(req_ready), 32'd1);
    chk("valid_drop", 32'(resp_valid), 32'd0);
    chk("clr_pulses", 32'(clr_total - clr_base), 32'(NE));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    logic seen;
    for (int i = 0; i < 16; i++) model_vals[i] = 8'h00;
    rst = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_enable", 32'(puf_enable), 32'd0);
    chk("rst_clr", 32'(puf_clr), 32'd0);
    chk("rst_challenge", 32'(puf_challenge), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_unstable", 32'(resp_unstable), 32'd0);
    rst = 1'b1;
    chk("ready_at_release", 32'(req_ready), 32'd0);
    tick();
    chk("ready_first_edge", 32'(req_ready), 32'd1);

    // Stable PUF
    for (int e = 0; e < NE; e++) model_vals[e] = 8'h3C;
    run_req(8'hA5, 0);

    // Disagreeing evaluations
    model_vals[0] = 8'hFF;
    model_vals[1] = 8'h0F;
    model_vals[2] = 8'h00;
    run_req(8'hC3, 2);

    // Long backpressure with an ignored request
    for (int e = 0; e < NE; e++) model_vals[e] = 8'($urandom);
    run_req(8'h5A, 20);

    // Reset in the middle of the second measurement window
    for (int e = 0; e < NE; e++) model_vals[e] = 8'($urandom);
    k = 0;
    while (!req_ready && k < 100) begin
      tick();
      k++;
    end
    clr_base      = clr_total;
    cur_chal      = 8'h3C;
    resp_ready    = 1'b1;
    req_valid     = 1'b1;
    req_challenge = 8'h3C;
    tick();
    req_valid = 1'b0;
    repeat (17) tick();
    chk("mid_measure_en", 32'(puf_enable), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_enable_drop", 32'(puf_enable), 32'd0);
    chk("rst_busy_drop", 32'(busy), 32'd0);
    chk("rst_ready_low", 32'(req_ready), 32'd0);
    chk("rst_chal_clear", 32'(puf_challenge), 32'd0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (resp_valid) seen = 1'b1;
    end
    chk("no_resp_after_rst", 32'(seen), 32'd0);
    for (int e = 0; e < NE; e++) model_vals[e] = 8'($urandom);
    run_req(8'h96, 0);

    // Back-to-back with resp_ready held high
    for (int e = 0; e < NE; e++) model_vals[e] = 8'($urandom);
    run_req(8'h01, 0);
    for (int e = 0; e < NE; e++) model_vals[e] = 8'($urandom);
    run_req(8'h02, 0);

    // Randomized requests
    for (int r = 0; r < 5; r++) begin
      for (int e = 0; e < NE; e++) model_vals[e] = 8'($urandom);
      run_req(8'($urandom), int'($urandom_range(0, 4)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/puf_eval_ctrl.md
PUF_EVAL_CTRL -- requirements
Module: puf_eval_ctrl

Interface
REQ-001 SHALL have parameter WINDOW_CYCLES, default 1024: number of cycles puf_enable is held high per evaluation (legal 1..65535).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4: number of cycles after puf_enable falls before puf_response is sampled (legal 1..255).
REQ-003 SHALL have parameter NUM_EVAL, default 5: number of evaluations per request; odd only, legal 1..15.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  1  challenge request valid.
REQ-007 SHALL have port req_ready  output  1  controller can accept a request.
REQ-008 SHALL have port req_challenge  input  8  challenge to evaluate.
REQ-009 SHALL have port puf_challenge  output  8  challenge driven to the PUF array.
REQ-010 SHALL have port puf_enable  output  1  ring-oscillator enable to the PUF array.
REQ-011 SHALL have port puf_clr  output  1  active-high one-cycle clear of the PUF counters.
REQ-012 SHALL have port puf_response  input  8  raw PUF response bits.
REQ-013 SHALL have port resp_valid  output  1  voted response available.
REQ-014 SHALL have port resp_ready  input  1  consumer accepts the response.
REQ-015 SHALL have port resp_data  output  8  majority-voted response.
REQ-016 SHALL have port resp_unstable  output  8  per-bit disagreement mask.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement the states IDLE, CLEAR, MEASURE, SETTLE, SAMPLE and DONE as one FSM.
REQ-019 In IDLE, req_ready SHALL be 1; on req_valid&req_ready it SHALL latch req_challenge into puf_challenge, zero all vote counters and the eval counter, and go to CLEAR.
REQ-020 CLEAR SHALL last 1 cycle with puf_clr=1, then go to MEASURE.
REQ-021 MEASURE SHALL last exactly WINDOW_CYCLES cycles with puf_enable=1, then go to SETTLE.
REQ-022 SETTLE SHALL last exactly SETTLE_CYCLES cycles with puf_enable=0, then go to SAMPLE.
REQ-023 SAMPLE SHALL last 1 cycle and add puf_response[i] to the 4-bit ones counter i (8 counters); it SHALL go to DONE if eval count = NUM_EVAL-1, otherwise increment eval count and go to CLEAR.
REQ-024 In DONE, resp_valid=1 and resp_data[i] = (ones[i] > NUM_EVAL/2), held stable until resp_valid&resp_ready; then IDLE, with req_ready=1 on the following cycle.
REQ-025 resp_valid SHALL first assert exactly NUM_EVAL*(WINDOW_CYCLES+SETTLE_CYCLES+2) cycles after the accepting edge.
REQ-026 puf_challenge SHALL remain constant from acceptance until the next accepted request; req_valid and req_challenge outside IDLE SHALL be ignored.
REQ-027 puf_clr and puf_enable SHALL never be high in the same cycle.
REQ-028 resp_ready while resp_valid=0 SHALL have no effect.

Reset
REQ-029 While rst=0, the FSM SHALL be IDLE, all counters 0, puf_challenge=0, puf_enable=0, puf_clr=0, resp_valid=0, resp_data=0, resp_unstable=0, busy=0, and req_ready=0.
REQ-030 Reset assertion in any state, including mid-MEASURE, SHALL immediately drop puf_enable, discard the partial vote and produce no response.
REQ-031 After rst deasserts, req_ready SHALL rise on the first clock edge.

Configuration
REQ-032 Macro PUF_EVAL_UNSTABLE_MASK_EN: when defined, in DONE resp_unstable[i] = 1 iff ones[i] != 0 and ones[i] != NUM_EVAL, valid with resp_data.
REQ-033 Without PUF_EVAL_UNSTABLE_MASK_EN, resp_unstable SHALL be constant 0, and the FSM, timing and resp_data SHALL be unchanged.

Verification (WINDOW_CYCLES=8, SETTLE_CYCLES=2, NUM_EVAL=3; behavioural PUF model)
REQ-034 req_challenge=0xA5 accepted, model returns 0x3C every evaluation: resp_valid rises exactly 36 cycles after acceptance; resp_data=0x3C; resp_unstable=0x00; puf_challenge=0xA5 throughout.
REQ-035 Model returns 0xFF, 0x0F, 0x00 in successive evaluations: resp_data=0x0F; resp_unstable=0xFF with the macro, 0x00 without it.
REQ-036 resp_ready held low 20 cycles in DONE: resp_valid and resp_data hold; a second req_valid with 0x11 is ignored; after resp_ready=1, IDLE and req_ready=1 on the next cycle.
REQ-037 rst=0 asserted at cycle 5 of the second MEASURE: puf_enable drops the same cycle; after release no resp_valid appears; a new request completes normally in 36 cycles.
REQ-038 Back-to-back requests 0x01 then 0x02 with resp_ready tied high: exactly 3 puf_clr pulses per request, puf_enable high 8 cycles per pulse, two responses in order, puf_clr never overlaps puf_enable.
